lbp_hist: RTL and testbench

LBP_HIST -- requirements
Module: lbp_hist

---
 rtl/lbp_hist.sv | 74 +++++++
 tb/tb_lbp_hist.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/lbp_hist.sv
// lbp_hist: 256-bin LBP code histogram with saturating counters and a ready/valid drain port
module lbp_hist #(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lbp_valid,
  input  logic [13:0]      lbp_addr,
  input  logic [7:0]       lbp_data,
  input  logic             finish,
  output logic             hist_valid,
  input  logic             hist_ready,
  output logic [7:0]       hist_bin,
  output logic [CNT_W-1:0] hist_count,
  output logic [CNT_W-1:0] sample_total,
  output logic             addr_err,
  output logic             hist_done
);
  typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_t                  state_q, state_d;
  logic [255:0][CNT_W-1:0] bins_q, bins_d;
  logic [CNT_W-1:0]        total_q, total_d;
  logic                    addr_err_q, addr_err_d;
  logic [7:0]              idx_q, idx_d;
  logic [6:0]              row, col;
  logic                    interior, sample;
  assign row      = lbp_addr[13:7];
  assign col      = lbp_addr[6:0];
  assign interior = (row != 7'd0) && (row != 7'h7f) && (col != 7'd0) && (col != 7'h7f);
  assign sample   = (state_q == ACCUM) && lbp_valid;
  // Accumulate interior samples into their bin and the total, flag border addresses
  always_comb begin
    bins_d     = bins_q;
    total_d    = total_q;
    addr_err_d = addr_err_q | (sample && !interior);
    if (sample && interior) begin
      bins_d[lbp_data] = (bins_q[lbp_data] == CNT_MAX) ? CNT_MAX : bins_q[lbp_data] + CNT_W'(1);
      total_d          = (total_q == CNT_MAX) ? CNT_MAX : total_q + CNT_W'(1);
    end
  end
  // Next state: finish starts the drain, each accepted beat advances the index, beat 255 ends it
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == ACCUM && finish) state_d = DRAIN;
    if (state_q == DRAIN && hist_ready) begin
      idx_d   = idx_q + 8'd1;
      state_d = (idx_q == 8'hff) ? DONE : DRAIN;
    end
  end
  // State registers, all cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ACCUM;
      bins_q     <= '0;
      total_q    <= '0;
      addr_err_q <= 1'b0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      bins_q     <= bins_d;
      total_q    <= total_d;
      addr_err_q <= addr_err_d;
      idx_q      <= idx_d;
    end
  end
  assign hist_valid   = (state_q == DRAIN);
  assign hist_done    = (state_q == DONE);
  assign hist_bin     = idx_q;
  assign hist_count   = hist_valid ? bins_q[idx_q] : '0;
  assign sample_total = total_q;
  assign addr_err     = addr_err_q;
endmodule

// File: tb/tb_lbp_hist.sv
// tb_lbp_hist: randomized self-checking bench for lbp_hist against a bin-array reference model
module tb_lbp_hist;
  localparam int CNT_W = 14;
  localparam int SAT   = (1 << CNT_W) - 1;
  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             lbp_valid = 1'b0;
  logic [13:0]      lbp_addr = '0;
  logic [7:0]       lbp_data = '0;
  logic             finish = 1'b0;
  logic             hist_valid;
  logic             hist_ready = 1'b0;
  logic [7:0]       hist_bin;
  logic [CNT_W-1:0] hist_count;
  logic [CNT_W-1:0] sample_total;
  logic             addr_err;
  logic             hist_done;
  int checks = 0;
  int failures = 0;
  int ref_bins [256];
  int ref_total;
  bit ref_err;
  lbp_hist #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
    .lbp_data(lbp_data), .finish(finish), .hist_valid(hist_valid), .hist_ready(hist_ready),
    .hist_bin(hist_bin), .hist_count(hist_count), .sample_total(sample_total),
    .addr_err(addr_err), .hist_done(hist_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic void model(input int addr, input int code);
    int r, c;
    r = addr / 128;
    c = addr % 128;
    if (r >= 1 && r <= 126 && c >= 1 && c <= 126) begin
      if (ref_bins[code] < SAT) ref_bins[code]++;
      if (ref_total < SAT) ref_total++;
    end else ref_err = 1'b1;
  endfunction
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    lbp_valid = 1'b0;
    finish = 1'b0;
    hist_ready = 1'b0;
    foreach (ref_bins[i]) ref_bins[i] = 0;
    ref_total = 0;
    ref_err = 1'b0;
    #1;
    chk("rst_valid", hist_valid, 0);
    chk("rst_done", hist_done, 0);
    chk("rst_total", sample_total, 0);
    chk("rst_err", addr_err, 0);
    chk("rst_bin", hist_bin, 0);
    chk("rst_count", hist_count, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic send(input int addr, input int code);
    @(negedge clk);
    lbp_valid = 1'b1;
    lbp_addr = 14'(addr);
    lbp_data = 8'(code);
    @(posedge clk);
    model(addr, code);
  endtask
  task automatic idle();
    @(negedge clk);
    lbp_valid = 1'b0;
  endtask
  task automatic fin(input bit with_sample, input int addr, input int code);
    @(negedge clk);
    finish = 1'b1;
    lbp_valid = with_sample;
    lbp_addr = 14'(addr);
    lbp_data = 8'(code);
    @(posedge clk);
    if (with_sample) model(addr, code);
  endtask
  task automatic rand_frame(input int n);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else if ($urandom_range(0, 4) == 0) send(int'($urandom_range(0, 16383)), int'($urandom_range(0, 255)));
      else send(int'($urandom_range(1, 126)) * 128 + int'($urandom_range(1, 126)), int'($urandom_range(0, 255)));
    end
    idle();
    chk("acc_total", sample_total, ref_total);
    chk("acc_err", addr_err, ref_err);
  endtask
  task automatic drain(input bit rnd, input bit inject, input int stop_at);
    int i = 0;
    int cyc = 0;
    while (i < 256 && i != stop_at && cyc < 4000) begin
      @(negedge clk);
      finish = 1'b0;
      lbp_valid = inject && cyc < 2;
      lbp_addr = 14'h0081;
      lbp_data = 8'h10;
      chk("drain_valid", hist_valid, 1);
      chk("drain_bin", hist_bin, i);
      chk("drain_count", hist_count, ref_bins[i]);
      chk("drain_total", sample_total, ref_total);
      chk("drain_err", addr_err, ref_err);
      hist_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      if (hist_ready) i++;
      cyc++;
    end
    if (cyc >= 4000) chk("drain_timeout", 0, 1);
    if (i == 256) begin
      @(negedge clk);
      hist_ready = 1'b0;
      lbp_valid = 1'b1;
      lbp_addr = 14'h0000;
      chk("done_valid", hist_valid, 0);
      chk("done_flag", hist_done, 1);
      @(negedge clk);
      lbp_valid = 1'b0;
      chk("done_hold", hist_done, 1);
      chk("done_total", sample_total, ref_total);
      chk("done_err", addr_err, ref_err);
    end
  endtask
  initial begin
    do_reset();
    send(16'h0081, 8'h05);
    send(16'h0081, 8'h05);
    send(16'h0081, 8'hff);
    idle();
    chk("small_bin5", ref_bins[5], 2);
    fin(1'b0, 0, 0);
    drain(1'b0, 1'b0, 256);
    do_reset();
    send(16'h0000, 8'h01);
    send(16'h3fff, 8'h02);
    idle();
    chk("border_err", addr_err, 1);
    chk("border_total", sample_total, 0);
    send(16'h0081, 8'h03);
    idle();
    chk("border_err_hold", addr_err, 1);
    chk("border_total_after", sample_total, 1);
    do_reset();
    for (int r = 1; r <= 126; r++)
      for (int c = 1; c <= 126; c++) send(r * 128 + c, 0);
    idle();
    chk("frame_total", sample_total, 15876);
    chk("frame_err", addr_err, 0);
    fin(1'b0, 0, 0);
    drain(1'b0, 1'b0, 256);
    do_reset();
    for (int k = 0; k < SAT + 7; k++) send(16'h0081, 8'h07);
    send(16'h0102, 8'h09);
    send(16'h0102, 8'h09);
    idle();
    chk("sat_total", sample_total, SAT);
    fin(1'b0, 0, 0);
    drain(1'b1, 1'b0, 256);
    do_reset();
    rand_frame(400);
    fin(1'b1, 16'h0081, 8'h10);
    drain(1'b1, 1'b1, 256);
    do_reset();
    rand_frame(300);
    fin(1'b0, 0, 0);
    drain(1'b1, 1'b0, 100);
    do_reset();
    rand_frame(60);
    fin(1'b1, 16'h1f3e, 8'h80);
    drain(1'b1, 1'b0, 256);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
